// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// serial_sub_pkg : shared encodings and limits for the bit-serial subtractor
// Revision: 1.0
// ============================================================================
package serial_sub_pkg;

   localparam int SUB_WMIN = 2;
   localparam int SUB_WMAX = 32;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Signed overflow of a - b: operand signs differ and the result sign
   // disagrees with the minuend.
   function automatic logic sub_ovf(input logic a_msb,
                                    input logic b_msb,
                                    input logic d_msb);
      return (a_msb != b_msb) && (d_msb != a_msb);
   endfunction

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/fullsubtractor.sv
`default_nettype none
// ============================================================================
// fullsubtractor : gate-level single-bit full subtractor (a - b - bin)
// Revision: 1.0
// ============================================================================
module fullsubtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   wire w_axb;
   wire w_na;
   wire w_nab;
   wire w_nx;
   wire w_nxb;

   xor u_x1  (w_axb, a, b);
   xor u_x2  (diff, w_axb, bin);
   not u_n1  (w_na, a);
   and u_a1  (w_nab, w_na, b);
   not u_n2  (w_nx, w_axb);
   and u_a2  (w_nxb, w_nx, bin);
   or  u_o1  (bout, w_nab, w_nxb);

endmodule : fullsubtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// serial_subtractor : bit-serial a - b, LSB first, WIDTH cycles per result
// Revision: 1.0
// ============================================================================
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             ovf
);

   localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   generate
      if (WIDTH < SUB_WMIN || WIDTH > SUB_WMAX) begin : g_width_check
         $error("serial_subtractor: WIDTH %0d outside legal range", WIDTH);
      end
   endgenerate

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] sd_q, sd_d;
   logic             bw_q, bw_d;
   logic             amsb_q, amsb_d;
   logic             bmsb_q, bmsb_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   logic             w_bit;
   logic             w_bout;
   logic             w_last;
   logic             w_accept;
   logic [WIDTH-1:0] w_sd_next;

   fullsubtractor u_fs (
      .a    (sa_q[0]),
      .b    (sb_q[0]),
      .bin  (bw_q),
      .diff (w_bit),
      .bout (w_bout)
   );

   assign w_accept  = (state_q == ST_IDLE) && start;
   assign w_last    = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
   assign w_sd_next = {w_bit, sd_q[WIDTH-1:1]};

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)  state_d = ST_RUN;
         ST_RUN:  if (w_last) state_d = ST_IDLE;
         default:             state_d = ST_IDLE;
      endcase
   end

   // ---------------- datapath next-state ----------------
   always_comb begin
      cnt_d  = cnt_q;
      sa_d   = sa_q;
      sb_d   = sb_q;
      sd_d   = sd_q;
      bw_d   = bw_q;
      amsb_d = amsb_q;
      bmsb_d = bmsb_q;
      if (w_accept) begin
         sa_d   = a;
         sb_d   = b;
         sd_d   = '0;
         bw_d   = 1'b0;
         cnt_d  = '0;
         amsb_d = a[WIDTH-1];
         bmsb_d = b[WIDTH-1];
      end else if (state_q == ST_RUN) begin
         sa_d  = {1'b0, sa_q[WIDTH-1:1]};
         sb_d  = {1'b0, sb_q[WIDTH-1:1]};
         sd_d  = w_sd_next;
         bw_d  = w_bout;
         // Parking at zero on the final bit keeps the counter from wrapping.
         cnt_d = w_last ? '0 : cnt_q + 1'b1;
      end
   end

   // ---------------- output logic ----------------
   always_comb begin
      done_d   = w_last;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      if (w_last) begin
         diff_d   = w_sd_next;
         borrow_d = w_bout;
         ovf_d    = sub_ovf(amsb_q, bmsb_q, w_bit);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         sa_q     <= '0;
         sb_q     <= '0;
         sd_q     <= '0;
         bw_q     <= 1'b0;
         amsb_q   <= 1'b0;
         bmsb_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         sd_q     <= sd_d;
         bw_q     <= bw_d;
         amsb_q   <= amsb_d;
         bmsb_q   <= bmsb_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   assign busy       = (state_q == ST_RUN);
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = borrow_q;
   assign ovf        = ovf_q;

endmodule : serial_subtractor
`default_nettype wire
